mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Two-port round-robin arbiter and sequencer for the multi-cycle main memory.
//  Port 0 (instruction fetch) and port 1 (data load/store) share the memory.
//  The block holds mem_read/mem_write and the address/data steady until the memory
//  completion flag, then returns read data and a one-cycle done pulse to the owner.
//  A watchdog aborts any access that fails to complete.
// PARAMETERS
//  add_width   10  memory word-address width
//  data_width  32  data word width
//  timeout     15  max ACCESS cycles before abort (must be >= 4; counter is 4 bits)
// PORTS
//  clk               in   1           rising-edge clock
//  rst_n             in   1           asynchronous, active-low reset
//  p0_req/p1_req     in   1           access request; held until that port's done
//  p0_we/p1_we       in   1           1 = write, 0 = read; stable while req=1
//  p0_add/p1_add     in   add_width   word address; stable while req=1
//  p0_wdata/p1_wdata in   data_width  write data; stable while req=1
//  p0_rdata/p1_rdata out  data_width  read data; valid while done=1, then held
//  p0_done/p1_done   out  1           one-cycle completion pulse
//  p0_err/p1_err     out  1           one-cycle pulse, coincident with done, on timeout
//  mem_add           out  add_width   address to memory
//  mem_write_data    out  data_width  write data to memory
//  mem_read          out  1           memory read strobe (level)
//  mem_write         out  1           memory write strobe (level)
//  mem_read_data     in   data_width  memory read data
//  mem_ready_to_read in   1           memory read-complete flag
//  mem_finished_writing in 1          memory write-complete flag
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, all outputs 0, wait_cnt=0, last_grant=1.
//  FSM states: IDLE, ACCESS, RESP. All outputs are registered.
//  IDLE: if any req=1 at the clock edge, grant one port and go to ACCESS.
//   The same edge loads mem_add, mem_write_data and mem_read=~we or mem_write=we.
//   If only one port requests, that port wins.
//   If both request, the winner is the port != last_grant; last_grant <= winner.
//   The first tie after reset goes to port 0.
//  ACCESS: memory strobes and fields are held; wait_cnt increments every cycle.
//   The completion flag is mem_ready_to_read for a read, mem_finished_writing for a write.
//   The flag is ignored while wait_cnt==0, so a stale flag from the previous access is
//   discarded.
//   Flag=1 with wait_cnt>=1: capture mem_read_data into the owner's rdata (reads only),
//   clear the strobes, and go to RESP.
//   wait_cnt==timeout with no flag: clear the strobes, set the err flag, and go to RESP.
//   On timeout, rdata is unchanged.
//  RESP: owner's done=1 (err=1 if aborted) for exactly this cycle; wait_cnt<=0; go to IDLE.
//   All req inputs are ignored in RESP.
//   The requester must drop req in the cycle after done, or IDLE treats it as a new request.
//  Only one of mem_read/mem_write is ever 1. Both are 0 in IDLE and RESP.
//  A change to the owner's req, we, add or wdata during ACCESS is ignored (already latched).
//  A non-owner req stays pending; it is served after RESP, and the ping-pong guarantees
//   no starvation.
//  Latency, request sampled to done: memory cycles + 2 (nominal 4-cycle memory -> 6 clks).
//  Reset mid-access: strobes drop immediately, no done/err is issued, and the aborted
//   access is lost.
// TESTING
//  1. p0 read, add=0x010, mem preloaded 0xDEADBEEF -> mem_read high for 4 clks; p0_done
//     pulses once; p0_rdata=0xDEADBEEF; p1 outputs stay 0.
//  2. p1 write, add=0x3FF, wdata=0x12345678; then p1 read of 0x3FF -> mem_write held until
//     finished_writing; the read returns 0x12345678.
//  3. p0 and p1 both request reads on the first cycle after reset -> p0 is served first,
//     then p1; both keep req high through two more rounds -> grants alternate 0,1,0,1.
//  4. Back-to-back accesses with a stale completion flag still high on entry to ACCESS ->
//     the flag is ignored at wait_cnt=0; done comes no earlier than wait_cnt=1.
//  5. Memory model never asserts completion, timeout=15 -> p1_done and p1_err pulse
//     together after 15 ACCESS clks; the strobes drop; p1_rdata is unchanged.
//  6. rst_n low in the middle of ACCESS -> all outputs 0 asynchronously; after release the
//     pending p1 req is granted and completes normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter and sequencer for a multi-cycle memory.
// Port 0 is instruction fetch and port 1 is data load/store.
// The granted access is latched and held on the memory bus until the memory
// raises its completion flag, or until the watchdog expires.
// The owner then gets a one-cycle done pulse, with err on a timeout.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   pN_req/we/add/wdata          request side of port N (held until pN_done)
//   pN_rdata/done/err            response side of port N (all registered)
//   mem_add/write_data/read/write  memory command bus (registered, held in ACCESS)
//   mem_read_data, mem_ready_to_read, mem_finished_writing   memory response
module mem_arbiter #(
  parameter int add_width  = 10,
  parameter int data_width = 32,
  parameter int timeout    = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [add_width-1:0]  p0_add,
  input  logic [data_width-1:0] p0_wdata,
  output logic [data_width-1:0] p0_rdata,
  output logic                  p0_done,
  output logic                  p0_err,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [add_width-1:0]  p1_add,
  input  logic [data_width-1:0] p1_wdata,
  output logic [data_width-1:0] p1_rdata,
  output logic                  p1_done,
  output logic                  p1_err,
  output logic [add_width-1:0]  mem_add,
  output logic [data_width-1:0] mem_write_data,
  output logic                  mem_read,
  output logic                  mem_write,
  input  logic [data_width-1:0] mem_read_data,
  input  logic                  mem_ready_to_read,
  input  logic                  mem_finished_writing
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [3:0] TO = 4'(timeout);

  state_t                state, state_nxt;
  logic                  owner, owner_nxt;
  logic                  last_grant, last_grant_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic [add_width-1:0]  mem_add_nxt;
  logic [data_width-1:0] mem_write_data_nxt;
  logic                  mem_read_nxt, mem_write_nxt;
  logic [data_width-1:0] p0_rdata_nxt, p1_rdata_nxt;
  logic                  p0_done_nxt, p1_done_nxt, p0_err_nxt, p1_err_nxt;
  logic                  win, flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      owner          <= 1'b0;
      last_grant     <= 1'b1;   // so the first tie goes to port 0
      wait_cnt       <= '0;
      mem_add        <= '0;
      mem_write_data <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      p0_rdata       <= '0;
      p1_rdata       <= '0;
      p0_done        <= 1'b0;
      p1_done        <= 1'b0;
      p0_err         <= 1'b0;
      p1_err         <= 1'b0;
    end else begin
      state          <= state_nxt;
      owner          <= owner_nxt;
      last_grant     <= last_grant_nxt;
      wait_cnt       <= wait_cnt_nxt;
      mem_add        <= mem_add_nxt;
      mem_write_data <= mem_write_data_nxt;
      mem_read       <= mem_read_nxt;
      mem_write      <= mem_write_nxt;
      p0_rdata       <= p0_rdata_nxt;
      p1_rdata       <= p1_rdata_nxt;
      p0_done        <= p0_done_nxt;
      p1_done        <= p1_done_nxt;
      p0_err         <= p0_err_nxt;
      p1_err         <= p1_err_nxt;
    end
  end

  always_comb begin
    state_nxt          = state;
    owner_nxt          = owner;
    last_grant_nxt     = last_grant;
    wait_cnt_nxt       = wait_cnt;
    mem_add_nxt        = mem_add;
    mem_write_data_nxt = mem_write_data;
    mem_read_nxt       = mem_read;
    mem_write_nxt      = mem_write;
    p0_rdata_nxt       = p0_rdata;
    p1_rdata_nxt       = p1_rdata;
    p0_done_nxt        = 1'b0;
    p1_done_nxt        = 1'b0;
    p0_err_nxt         = 1'b0;
    p1_err_nxt         = 1'b0;
    // a lone requester wins; on a tie the port that did not win last time wins
    win  = (p0_req && p1_req) ? ~last_grant : p1_req;
    flag = mem_read ? mem_ready_to_read : mem_finished_writing;
    case (state)
      IDLE: begin
        mem_read_nxt  = 1'b0;
        mem_write_nxt = 1'b0;
        if (p0_req || p1_req) begin
          owner_nxt          = win;
          last_grant_nxt     = win;
          mem_add_nxt        = win ? p1_add : p0_add;
          mem_write_data_nxt = win ? p1_wdata : p0_wdata;
          mem_read_nxt       = win ? ~p1_we : ~p0_we;
          mem_write_nxt      = win ? p1_we : p0_we;
          wait_cnt_nxt       = '0;
          state_nxt          = ACCESS;
        end
      end
      ACCESS: begin
        wait_cnt_nxt = wait_cnt + 4'd1;
        // at wait_cnt==0 the flag may still be left over from the previous access
        if (wait_cnt != 4'd0 && flag) begin
          if (mem_read) begin
            if (owner) p1_rdata_nxt = mem_read_data;
            else       p0_rdata_nxt = mem_read_data;
          end
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          p0_done_nxt   = ~owner;
          p1_done_nxt   = owner;
          state_nxt     = RESP;
        end else if (wait_cnt == TO) begin
          mem_read_nxt  = 1'b0;
          mem_write_nxt = 1'b0;
          p0_done_nxt   = ~owner;
          p1_done_nxt   = owner;
          p0_err_nxt    = ~owner;
          p1_err_nxt    = owner;
          state_nxt     = RESP;
        end
      end
      RESP: begin
        wait_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
